ternary_weight_packer: RTL and testbench



---
 rtl/ternary_weight_packer_if.sv | 27 ++
 rtl/ternary_weight_packer.sv | 122 ++++++++++++
 tb/tb_ternary_weight_packer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ternary_weight_packer_if.sv
// Stream bundle between the weight source, the ternary packer and the select array.
// Valid/ready: a beat transfers on a rising edge where valid and ready are both 1;
// a producer holds valid and data stable until that edge, and ready may not depend on valid.
interface ternary_weight_packer_if #(
  parameter int WIN_WIDTH  = 8,
  parameter int WORD_WIDTH = 200
);
  logic                   clear;
  logic [WIN_WIDTH-2:0]   threshold;
  logic                   w_valid;
  logic [WIN_WIDTH-1:0]   w_data;
  logic                   w_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic [WORD_WIDTH-1:0]  weight_out;
  logic [15:0]            word_count;

  modport master (
    output clear, threshold, w_valid, w_data, out_ready,
    input  w_ready, out_valid, weight_out, word_count
  );

  modport slave (
    input  clear, threshold, w_valid, w_data, out_ready,
    output w_ready, out_valid, weight_out, word_count
  );
endinterface

// File: rtl/ternary_weight_packer.sv
// Ternarises a stream of signed weights against a threshold and packs N 2-bit codes
// into one word, handed downstream through a single-entry valid/ready output register.
module ternary_weight_packer #(
  parameter int TN           = 4,
  parameter int KERNEL_SIZE  = 5,
  parameter int KERNEL_WIDTH = 2,
  parameter int WIN_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ternary_weight_packer_if.slave bus,
  output logic                  dbg_state_o
);
  localparam int N         = TN * KERNEL_SIZE * KERNEL_SIZE;
  localparam int CNT_WIDTH = $clog2(N);
  localparam int WORD_W    = N * KERNEL_WIDTH;

  if (KERNEL_WIDTH != 2) begin : g_bad_kernel_width
    $error("ternary_weight_packer: KERNEL_WIDTH must be 2");
  end

  typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [WORD_W-1:0]      pack_q, pack_d;
  logic [WORD_W-1:0]      out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic [15:0]            word_count_q, word_count_d;

  logic signed [WIN_WIDTH:0] w_ext, thr_pos, thr_neg;
  logic [1:0]                code;
  logic                      accept;
  logic                      slot_free;

  // One extra bit so that -threshold and -128 both compare without overflow.
  assign w_ext   = {bus.w_data[WIN_WIDTH-1], bus.w_data};
  assign thr_pos = {2'b00, bus.threshold};
  assign thr_neg = -thr_pos;

  always_comb begin
    code = 2'b00;
    if (w_ext > thr_pos) begin
      code = 2'b01;
    end else if (w_ext < thr_neg) begin
      code = 2'b11;
    end
  end

  assign accept    = bus.w_valid && (state_q == FILL) && !bus.clear;
  assign slot_free = !out_valid_q || bus.out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pack_d       = pack_q;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    word_count_d = word_count_q;

    if (bus.clear) begin
      state_d      = FILL;
      cnt_d        = '0;
      pack_d       = '0;
      out_valid_d  = 1'b0;
      word_count_d = '0;
    end else begin
      // A handoff in the same cycle overrides this and keeps out_valid high.
      if (out_valid_q && bus.out_ready) begin
        out_valid_d = 1'b0;
      end

      case (state_q)
        FILL: begin
          if (accept) begin
            pack_d[{cnt_q, 1'b0} +: 2] = code;
            if (cnt_q == CNT_WIDTH'(N - 1)) begin
              cnt_d   = '0;
              state_d = FULL;
            end else begin
              cnt_d = cnt_q + CNT_WIDTH'(1);
            end
          end
        end
        FULL: begin
          if (slot_free) begin
            out_d        = pack_q;
            out_valid_d  = 1'b1;
            word_count_d = word_count_q + 16'd1;
            pack_d       = '0;
            state_d      = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      pack_q       <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pack_q       <= pack_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.w_ready    = (state_q == FILL);
  assign bus.out_valid  = out_valid_q;
  assign bus.weight_out = out_q;
  assign bus.word_count = word_count_q;
  assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_ternary_weight_packer.sv
// Directed bench for ternary_weight_packer: a queue-based cycle model checked every cycle,
// plus hand-computed literal words pinning encode, latency, backpressure, reset and clear.
module tb_ternary_weight_packer;
  localparam int N  = 100;
  localparam int WW = 200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dbg_state;
  always #5 clk = ~clk;

  ternary_weight_packer_if #(.WIN_WIDTH(8), .WORD_WIDTH(WW)) bus ();

  ternary_weight_packer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  logic [1:0]    code_q[$];
  logic [WW-1:0] exp_q[$];
  logic          mod_ov;
  logic [WW-1:0] mod_out;
  logic [15:0]   mod_wc;

  function automatic logic [1:0] enc(input logic [7:0] d, input logic [6:0] t);
    int w;
    int th;
    w  = int'($signed(d));
    th = int'(t);
    if (w > th) return 2'b01;
    if (w < -th) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [WW-1:0] pack_codes();
    logic [WW-1:0] word;
    word = '0;
    for (int i = 0; i < N; i++) word[2*i +: 2] = code_q[i];
    return word;
  endfunction

  initial begin
    mod_ov = 1'b0;
    mod_out = '0;
    mod_wc = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        code_q.delete();
        exp_q.delete();
        mod_ov = 1'b0;
        mod_wc = '0;
      end else begin
        check("w_ready", WW'(bus.w_ready), WW'(exp_q.size() == 0));
        check("out_valid", WW'(bus.out_valid), WW'(mod_ov));
        check("word_count", WW'(bus.word_count), WW'(mod_wc));
        if (mod_ov) check("weight_out", bus.weight_out, mod_out);
        if (bus.clear) begin
          code_q.delete();
          exp_q.delete();
          mod_ov = 1'b0;
          mod_wc = '0;
        end else if (exp_q.size() != 0) begin
          if (!mod_ov || bus.out_ready) begin
            mod_out = exp_q.pop_front();
            mod_ov  = 1'b1;
            mod_wc++;
          end
        end else begin
          if (mod_ov && bus.out_ready) mod_ov = 1'b0;
          if (bus.w_valid) begin
            code_q.push_back(enc(bus.w_data, bus.threshold));
            if (code_q.size() == N) begin
              exp_q.push_back(pack_codes());
              code_q.delete();
            end
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_weight_w(input logic [7:0] d, output int waits);
    logic rdy;
    bus.w_valid = 1'b1;
    bus.w_data  = d;
    waits = 0;
    forever begin
      @(negedge clk);
      rdy = bus.w_ready;
      @(posedge clk);
      #1;
      if (rdy) break;
      waits++;
      if (waits > 500) begin
        check("send_timeout", 1'b0, 1'b1);
        break;
      end
    end
  endtask

  task automatic send_weight(input logic [7:0] d);
    int waits;
    send_weight_w(d, waits);
  endtask

  task automatic end_burst();
    bus.w_valid = 1'b0;
    bus.w_data  = '0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    @(posedge clk);
    #1 bus.clear = 1'b0;
  endtask

  task automatic wait_word(input string name, input logic [WW-1:0] exp_word, input logic [15:0] exp_wc);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 400) begin
      n++;
      @(negedge clk);
    end
    check({name, "_valid"}, WW'(bus.out_valid), WW'(1));
    check({name, "_word"}, bus.weight_out, exp_word);
    check({name, "_count"}, WW'(bus.word_count), WW'(exp_wc));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  // ---------------- directed tests ----------------
  logic [7:0]    enc_v[7];
  logic [WW-1:0] all_pos, all_neg, restart_word, clear_word;
  int            bubbles, w;

  initial begin
    enc_v = '{8'd11, 8'd10, 8'hF6, 8'hF5, 8'd0, 8'd127, 8'h80};
    all_pos      = {N{2'b01}};
    all_neg      = {N{2'b11}};
    restart_word = {{99{2'b01}}, 2'b11};
    clear_word   = {2'b01, {33{6'b001101}}};

    bus.clear = 1'b0;
    bus.threshold = 7'd10;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_valid", WW'(bus.out_valid), '0);
    check("rst_weight_out", bus.weight_out, '0);
    check("rst_word_count", WW'(bus.word_count), '0);
    check("rst_w_ready", WW'(bus.w_ready), WW'(1));
    @(posedge clk);
    #1;

    // encode: {11,10,-10,-11,0,127,-128} -> {01,00,00,11,00,01,11}
    for (int i = 0; i < 7; i++) send_weight(enc_v[i]);
    for (int i = 7; i < N; i++) send_weight(8'd0);
    end_burst();
    wait_word("encode", 200'h34C1, 16'd1);

    // stream: out_valid exactly two cycles after the last accept
    bus.out_ready = 1'b1;
    for (int i = 0; i < N; i++) send_weight(8'd20);
    end_burst();
    @(negedge clk);
    check("lat_t1_valid", WW'(bus.out_valid), '0);
    @(negedge clk);
    check("lat_t2_valid", WW'(bus.out_valid), WW'(1));
    check("lat_t2_word", bus.weight_out, all_pos);
    check("lat_t2_count", WW'(bus.word_count), WW'(2));
    @(posedge clk);
    #1;
    bubbles = 0;
    for (int i = 0; i < 2 * N; i++) begin
      send_weight_w(8'd20, w);
      bubbles += w;
    end
    end_burst();
    check("stream_bubbles", WW'(bubbles), WW'(1));
    repeat (4) @(posedge clk);
    #1 bus.out_ready = 1'b0;

    // async reset mid-fill
    for (int i = 0; i < 50; i++) send_weight(8'd20);
    end_burst();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", WW'(bus.out_valid), '0);
    check("midrst_weight_out", bus.weight_out, '0);
    check("midrst_word_count", WW'(bus.word_count), '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_w_ready", WW'(bus.w_ready), WW'(1));
    @(posedge clk);
    #1;
    send_weight(8'hEC);
    for (int i = 1; i < N; i++) send_weight(8'd20);
    end_burst();
    wait_word("restart", restart_word, 16'd1);

    // backpressure: second word stalls in FULL
    pulse_clear();
    for (int i = 0; i < N; i++) send_weight(8'd20);
    for (int i = 0; i < N; i++) send_weight(8'hEC);
    end_burst();
    repeat (3) @(negedge clk);
    check("bp_w_ready", WW'(bus.w_ready), '0);
    check("bp_out_valid", WW'(bus.out_valid), WW'(1));
    check("bp_held_word", bus.weight_out, all_pos);
    check("bp_held_count", WW'(bus.word_count), WW'(1));
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_first_word", bus.weight_out, all_pos);
    @(negedge clk);
    check("bp_second_word", bus.weight_out, all_neg);
    check("bp_second_valid", WW'(bus.out_valid), WW'(1));
    check("bp_count", WW'(bus.word_count), WW'(2));
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    check("bp_drained", WW'(bus.out_valid), '0);
    @(posedge clk);
    #1;

    // clear after 37 accepts, with a w_valid in the clear cycle
    for (int i = 0; i < 37; i++) send_weight(8'd20);
    bus.clear   = 1'b1;
    bus.w_valid = 1'b1;
    bus.w_data  = 8'hEC;
    @(posedge clk);
    #1;
    bus.clear = 1'b0;
    end_burst();
    for (int i = 0; i < N; i++) begin
      case (i % 3)
        0: send_weight(8'd20);
        1: send_weight(8'hEC);
        default: send_weight(8'd0);
      endcase
    end
    end_burst();
    wait_word("clear", clear_word, 16'd1);

    // thresholds at the extremes
    bus.threshold = 7'd127;
    for (int i = 0; i < N; i++) send_weight((i % 2 == 0) ? 8'd127 : 8'h81);
    end_burst();
    wait_word("thr127", '0, 16'd2);
    bus.threshold = 7'd0;
    send_weight(8'd0);
    send_weight(8'd1);
    send_weight(8'hFF);
    for (int i = 3; i < N; i++) send_weight(8'd0);
    end_burst();
    wait_word("thr0", 200'h34, 16'd3);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
